iot_event_arbiter: RTL and testbench
====================================

# iot_event_arbiter

Upstream stage of the active-IoT-device monitor. It collects connect/disconnect requests from `N_DEV` devices and serialises them, at most one per cycle, into the single-bit `change`/`on_off` event stream that the monitor counter consumes. It keeps a per-device active mask so that redundant requests (on→on, off→off) are acknowledged but never reach the counter. Arbitration between devices is round-robin.

## Interface
Parameters:
- `N_DEV`, default 8: number of devices; legal range 2..64.
- `ID_W`, default `$clog2(N_DEV)`: width of `grant_id`.

Ports:
- `clk`: in, 1 bit. Clock; all state updates on the rising edge.
- `rst`: in, 1 bit. Reset: synchronous, active-high.
- `dev_req`: in, `N_DEV` bits. Per-device request. Held high until that device's `dev_ack` is seen.
- `dev_on`: in, `N_DEV` bits. Requested state per device (1 = connect, 0 = disconnect). Must be stable while `dev_req[i]` is high.
- `dev_ack`: out, `N_DEV` bits. One-hot, single-cycle acknowledge to the served device.
- `grant_id`: out, `ID_W` bits. Index of the last served device.
- `change`: out, 1 bit. One-cycle pulse; high when the served request altered that device's state.
- `on_off`: out, 1 bit. Direction of the event (1 = connect). Valid only with `change`; 0 otherwise.
- `active_mask`: out, `N_DEV` bits. Current connected state of every device.

## Operation
- **Internal state:** round-robin pointer `ptr` (`ID_W` bits), registered copy of last-cycle `dev_ack` (`ack_q`), plus all outputs. Every output is a register; none is driven combinationally from the inputs.
- **Reset:** when `rst`=1 at an edge, `dev_ack`=0, `grant_id`=0, `change`=0, `on_off`=0, `active_mask`=0, `ptr`=0, `ack_q`=0. Reset takes priority over everything else.
- **Eligible set:** `elig = dev_req & ~ack_q`. This masks out a device in the cycle after its ack, while its request is still high.
- **Selection:** the first set bit of `elig`, searching upward from index `ptr` and wrapping from `N_DEV-1` to 0. Call it device `i`.
- **Serve (at the edge, when `elig` is non-zero):**
  - `dev_ack` = one-hot(`i`); `grant_id` = `i`.
  - If `dev_on[i]` != `active_mask[i]`: `change`=1, `on_off`=`dev_on[i]`, and `active_mask[i]` takes the value `dev_on[i]`.
  - Otherwise (redundant request): `change`=0, `on_off`=0, and `active_mask` is unchanged.
  - `ptr` = (`i`+1) mod `N_DEV`.
- **Idle (`elig`=0):** `dev_ack`=0, `change`=0, `on_off`=0. `grant_id`, `ptr` and `active_mask` hold.
- **Device protocol:** a device drops `dev_req` in the cycle after it sees `dev_ack`. A request still high two cycles after its ack is treated as a new request.
- **Invariant:** the sum of `change`&`on_off` pulses minus the sum of `change`&~`on_off` pulses since reset equals popcount(`active_mask`). This equals `counter_out` of a downstream monitor reset at the same time, mod 256.

## Timing
- **Latency:** a request sampled at edge k produces `dev_ack`/`change` registered at edge k, visible during cycle k→k+1. The monitor samples `change` at edge k+1.
- **Throughput:** one serviced request per cycle in aggregate; one per two cycles per device.
- **Fairness:** with all `N_DEV` devices requesting continuously, each is served exactly once every `N_DEV` cycles.
- **Simultaneous requests:** only one device is served per cycle. The others wait, with their requests held.
- **Reset mid-operation:** all pending grants are discarded and `active_mask` clears. Requests still held after `rst` falls are arbitrated from `ptr`=0 on the first non-reset edge.
- **Wrap-around:** the search wraps past index `N_DEV-1` to index 0.

## Test plan
Scenarios use `N_DEV`=4.
1. **Reset:** drive `rst`=1 with `dev_req`=4'b1111 → all outputs 0 for every reset cycle. The first edge after release gives `dev_ack`=4'b0001, `change`=1, `on_off`=1 for `dev_on`=4'b1111.
2. **Single connect/disconnect:** dev2 requests on → `dev_ack`=4'b0100, `change`=1, `on_off`=1, `active_mask`=4'b0100. Later dev2 requests off → `change`=1, `on_off`=0, `active_mask`=0.
3. **Redundant request:** with dev1 already on, dev1 requests on again → `dev_ack`=4'b0010, `change`=0, `on_off`=0, `active_mask` unchanged.
4. **Round-robin:** all four devices hold on-requests from `ptr`=0 → acks 0001, 0010, 0100, 1000 on consecutive cycles with `change`=1 each. `active_mask`=4'b1111 and popcount is 4.
5. **Wrap and rotation:** with `ptr`=3 after serving dev2, dev0 and dev3 request together → dev3 is served first, then dev0.
6. **Reset mid-stream:** assert `rst` on the cycle dev1 is acked while dev3 is pending → `active_mask`=0 and `change`=0. After release, dev3 is served from `ptr`=0 order, then a downstream-count check against popcount(`active_mask`).

Source files
------------

// File: rtl/iot_event_arbiter.sv
// iot_event_arbiter
//   Collects connect/disconnect requests from N_DEV devices and serialises them, at most one per
//   cycle, into a change/on_off event stream. A per-device active mask filters redundant requests
//   (acknowledged but not forwarded). Arbitration is round-robin starting at ptr.
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   dev_req     : per-device request, held until acknowledged
//   dev_on      : requested state per device (1 = connect), stable while dev_req is high
//   dev_ack     : one-hot single-cycle acknowledge (registered)
//   grant_id    : index of the last served device (registered)
//   change      : one-cycle pulse when the served request altered the device state
//   on_off      : event direction, valid with change, 0 otherwise
//   active_mask : current connected state of every device
module iot_event_arbiter #(
   parameter int unsigned N_DEV = 8,
   parameter int unsigned ID_W  = $clog2(N_DEV)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_DEV-1:0] dev_req,
   input  logic [N_DEV-1:0] dev_on,
   output logic [N_DEV-1:0] dev_ack,
   output logic [ID_W-1:0]  grant_id,
   output logic             change,
   output logic             on_off,
   output logic [N_DEV-1:0] active_mask
);

   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [N_DEV-1:0] ack_q, ack_d;
   logic [ID_W-1:0]  grant_q, grant_d;
   logic             change_q, change_d;
   logic             on_off_q, on_off_d;
   logic [N_DEV-1:0] mask_q, mask_d;

   logic [N_DEV-1:0] elig;
   logic             sel_valid;
   logic [ID_W-1:0]  sel_idx;
   int unsigned      idx;

   // A device acked last cycle still has its request up; keep it out of this round.
   assign elig = dev_req & ~ack_q;

   // Round-robin search: first eligible index at or above ptr, wrapping to 0.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      idx       = 0;
      for (int unsigned k = 0; k < N_DEV; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= N_DEV) begin
            idx = idx - N_DEV;
         end
         if (!sel_valid && elig[idx]) begin
            sel_valid = 1'b1;
            sel_idx   = ID_W'(idx);
         end
      end
   end

   always_comb begin
      ack_d    = '0;
      grant_d  = grant_q;
      change_d = 1'b0;
      on_off_d = 1'b0;
      mask_d   = mask_q;
      ptr_d    = ptr_q;
      if (sel_valid) begin
         ack_d[sel_idx] = 1'b1;
         grant_d        = sel_idx;
         // Only a real state transition reaches the downstream counter.
         if (dev_on[sel_idx] != mask_q[sel_idx]) begin
            change_d        = 1'b1;
            on_off_d        = dev_on[sel_idx];
            mask_d[sel_idx] = dev_on[sel_idx];
         end
         ptr_d = (sel_idx == ID_W'(N_DEV - 1)) ? '0 : sel_idx + ID_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q    <= '0;
         ack_q    <= '0;
         grant_q  <= '0;
         change_q <= 1'b0;
         on_off_q <= 1'b0;
         mask_q   <= '0;
      end else begin
         ptr_q    <= ptr_d;
         ack_q    <= ack_d;
         grant_q  <= grant_d;
         change_q <= change_d;
         on_off_q <= on_off_d;
         mask_q   <= mask_d;
      end
   end

   // ack_q doubles as the dev_ack output register.
   assign dev_ack     = ack_q;
   assign grant_id    = grant_q;
   assign change      = change_q;
   assign on_off      = on_off_q;
   assign active_mask = mask_q;

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Testbench for iot_event_arbiter with N_DEV = 4: directed scenarios plus randomized device
// traffic checked against a behavioural model and a downstream event counter.
module tb_iot_event_arbiter;

   localparam int N = 4;
   localparam int W = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] dev_req;
   logic [N-1:0] dev_on;
   logic [N-1:0] dev_ack;
   logic [W-1:0] grant_id;
   logic         change;
   logic         on_off;
   logic [N-1:0] active_mask;

   iot_event_arbiter #(
      .N_DEV(N),
      .ID_W (W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .dev_req    (dev_req),
      .dev_on     (dev_on),
      .dev_ack    (dev_ack),
      .grant_id   (grant_id),
      .change     (change),
      .on_off     (on_off),
      .active_mask(active_mask)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [N-1:0] m_mask;
   int           m_ptr;
   int           m_last;       // device served at the previous edge, -1 if none
   logic [N-1:0] e_ack;
   logic [W-1:0] e_grant;
   logic         e_change;
   logic         e_onoff;
   logic [7:0]   ds_count;     // downstream monitor counter driven by DUT events

   // Advance the model by one edge using the current inputs, then clock the DUT.
   task automatic tick();
      int   win;
      logic r;
      win = -1;
      r   = rst;
      if (rst) begin
         m_mask   = '0;
         m_ptr    = 0;
         m_last   = -1;
         e_ack    = '0;
         e_grant  = '0;
         e_change = 1'b0;
         e_onoff  = 1'b0;
      end else begin
         for (int d = 0; d < N; d++) begin
            if (win < 0 && dev_req[(m_ptr + d) % N] && ((m_ptr + d) % N) != m_last) begin
               win = (m_ptr + d) % N;
            end
         end
         if (win >= 0) begin
            e_ack      = '0;
            e_ack[win] = 1'b1;
            e_grant    = W'(win);
            if (dev_on[win] != m_mask[win]) begin
               e_change    = 1'b1;
               e_onoff     = dev_on[win];
               m_mask[win] = dev_on[win];
            end else begin
               e_change = 1'b0;
               e_onoff  = 1'b0;
            end
            m_ptr  = (win + 1) % N;
            m_last = win;
         end else begin
            e_ack    = '0;
            e_change = 1'b0;
            e_onoff  = 1'b0;
            m_last   = -1;
         end
      end
      @(posedge clk);
      #1;
      if (r) ds_count = 8'd0;
      else if (change) ds_count = on_off ? ds_count + 8'd1 : ds_count - 8'd1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      dev_req = '0;
      dev_on  = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      dev_req = 4'b1111;
      dev_on  = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if ({dev_ack, grant_id, change, on_off, active_mask} !== 12'b0) begin
            n_err++;
            $display("FAIL reset_outputs cyc%0d: got ack=%b gid=%0d chg=%b oo=%b mask=%b want all 0",
                     c, dev_ack, grant_id, change, on_off, active_mask);
         end
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if ({dev_ack, grant_id, change, on_off, active_mask} !== {4'b0001, 2'd0, 1'b1, 1'b1, 4'b0001})
      begin
         n_err++;
         $display("FAIL reset_release: got ack=%b gid=%0d chg=%b oo=%b mask=%b want 0001/0/1/1/0001",
                  dev_ack, grant_id, change, on_off, active_mask);
      end
      dev_req = '0;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      dev_req = 4'b0100;
      dev_on  = 4'b0100;
      tick();
      n_cmp++;
      if ({dev_ack, grant_id, change, on_off, active_mask} !== {4'b0100, 2'd2, 1'b1, 1'b1, 4'b0100})
      begin
         n_err++;
         $display("FAIL single_on: got ack=%b gid=%0d chg=%b oo=%b mask=%b want 0100/2/1/1/0100",
                  dev_ack, grant_id, change, on_off, active_mask);
      end
      dev_req = '0;
      tick();
      n_cmp++;
      if ({dev_ack, grant_id, change, on_off, active_mask} !== {4'b0000, 2'd2, 1'b0, 1'b0, 4'b0100})
      begin
         n_err++;
         $display("FAIL single_idle: got ack=%b gid=%0d chg=%b oo=%b mask=%b want 0000/2/0/0/0100",
                  dev_ack, grant_id, change, on_off, active_mask);
      end
      dev_req = 4'b0100;
      dev_on  = 4'b0000;
      tick();
      n_cmp++;
      if ({dev_ack, change, on_off, active_mask} !== {4'b0100, 1'b1, 1'b0, 4'b0000}) begin
         n_err++;
         $display("FAIL single_off: got ack=%b chg=%b oo=%b mask=%b want 0100/1/0/0000",
                  dev_ack, change, on_off, active_mask);
      end
      dev_req = '0;
      tick();
   endtask

   task automatic test_redundant();
      do_reset();
      dev_req = 4'b0010;
      dev_on  = 4'b0010;
      tick();
      dev_req = '0;
      tick();
      dev_req = 4'b0010;
      tick();
      n_cmp++;
      if ({dev_ack, grant_id, change, on_off, active_mask} !== {4'b0010, 2'd1, 1'b0, 1'b0, 4'b0010})
      begin
         n_err++;
         $display("FAIL redundant: got ack=%b gid=%0d chg=%b oo=%b mask=%b want 0010/1/0/0/0010",
                  dev_ack, grant_id, change, on_off, active_mask);
      end
      dev_req = '0;
      tick();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] want_ack;
      logic [N-1:0] want_mask;
      do_reset();
      dev_req = 4'b1111;
      dev_on  = 4'b1111;
      for (int k = 0; k < 2 * N; k++) begin
         tick();
         want_ack  = 4'b0001 << (k % N);
         want_mask = (k < N) ? (4'b1111 >> (N - 1 - k)) : 4'b1111;
         n_cmp++;
         if ({dev_ack, grant_id, change, on_off, active_mask} !==
             {want_ack, W'(k % N), k < N, k < N, want_mask}) begin
            n_err++;
            $display("FAIL round_robin k=%0d: got ack=%b gid=%0d chg=%b oo=%b mask=%b want ack=%b mask=%b",
                     k, dev_ack, grant_id, change, on_off, active_mask, want_ack, want_mask);
         end
      end
      n_cmp++;
      if (ds_count !== 8'd4) begin
         n_err++;
         $display("FAIL rr_count: got %0d want 4", ds_count);
      end
      dev_req = '0;
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      dev_req = 4'b0100;
      dev_on  = 4'b0100;
      tick();
      dev_req = 4'b1001;
      dev_on  = 4'b1001;
      tick();
      n_cmp++;
      if ({dev_ack, grant_id} !== {4'b1000, 2'd3}) begin
         n_err++;
         $display("FAIL wrap_first: got ack=%b gid=%0d want 1000/3", dev_ack, grant_id);
      end
      tick();
      n_cmp++;
      if ({dev_ack, grant_id, change, on_off, active_mask} !== {4'b0001, 2'd0, 1'b1, 1'b1, 4'b1101})
      begin
         n_err++;
         $display("FAIL wrap_second: got ack=%b gid=%0d chg=%b oo=%b mask=%b want 0001/0/1/1/1101",
                  dev_ack, grant_id, change, on_off, active_mask);
      end
      dev_req = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      dev_req = 4'b1010;
      dev_on  = 4'b1010;
      tick();
      n_cmp++;
      if ({dev_ack, change, active_mask} !== {4'b0010, 1'b1, 4'b0010}) begin
         n_err++;
         $display("FAIL mid_first: got ack=%b chg=%b mask=%b want 0010/1/0010",
                  dev_ack, change, active_mask);
      end
      rst     = 1'b1;
      dev_req = 4'b1000;
      tick();
      n_cmp++;
      if ({dev_ack, change, on_off, active_mask} !== 10'b0) begin
         n_err++;
         $display("FAIL mid_reset: got ack=%b chg=%b oo=%b mask=%b want all 0",
                  dev_ack, change, on_off, active_mask);
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if ({dev_ack, grant_id, change, on_off, active_mask} !== {4'b1000, 2'd3, 1'b1, 1'b1, 4'b1000})
      begin
         n_err++;
         $display("FAIL mid_after: got ack=%b gid=%0d chg=%b oo=%b mask=%b want 1000/3/1/1/1000",
                  dev_ack, grant_id, change, on_off, active_mask);
      end
      n_cmp++;
      if (ds_count !== 8'd1) begin
         n_err++;
         $display("FAIL mid_count: got %0d want 1", ds_count);
      end
      dev_req = '0;
      tick();
   endtask

   task automatic test_random();
      bit drop_next [N];
      do_reset();
      for (int i = 0; i < N; i++) drop_next[i] = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (drop_next[i]) begin
               dev_req[i]   = 1'b0;
               drop_next[i] = 1'b0;
            end else if (dev_req[i] && dev_ack[i]) begin
               if ($urandom_range(1) == 1) dev_req[i] = 1'b0;
               else drop_next[i] = 1'b1;
            end else if (!dev_req[i] && $urandom_range(2) == 0) begin
               dev_req[i] = 1'b1;
               dev_on[i]  = 1'($urandom_range(1));
            end
         end
         rst = ($urandom_range(49) == 0);
         tick();
         n_cmp++;
         if ({dev_ack, grant_id, change, on_off, active_mask} !==
             {e_ack, e_grant, e_change, e_onoff, m_mask}) begin
            n_err++;
            $display("FAIL random cyc%0d: got ack=%b gid=%0d chg=%b oo=%b mask=%b want ack=%b gid=%0d chg=%b oo=%b mask=%b",
                     cyc, dev_ack, grant_id, change, on_off, active_mask,
                     e_ack, e_grant, e_change, e_onoff, m_mask);
         end
         n_cmp++;
         if (ds_count !== 8'($countones(m_mask))) begin
            n_err++;
            $display("FAIL random_count cyc%0d: got %0d want %0d", cyc, ds_count,
                     $countones(m_mask));
         end
      end
      rst     = 1'b0;
      dev_req = '0;
      tick();
   endtask

   initial begin
      rst      = 1'b1;
      dev_req  = '0;
      dev_on   = '0;
      ds_count = 8'd0;
      m_mask   = '0;
      m_ptr    = 0;
      m_last   = -1;
      test_reset();
      test_single();
      test_redundant();
      test_round_robin();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
